// File: rtl/alu_mp_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_mp_sequencer_if
// Byte-wide bus between the multi-precision sequencer and an 8-bit ALU.
//   alu_in1, alu_in2 : operand bytes (in1 is the minuend for subtraction)
//   alu_cin          : carry/borrow into the ALU
//   alu_opcode       : ALU function code
//   alu_out          : combinational ALU result byte
//   alu_cout         : ALU carry (add) or borrow (sub) out
//   alu_z            : ALU result-byte-is-zero flag
// Modports: master = sequencer side, slave = ALU side.
// ---------------------------------------------------------------------------
interface alu_mp_sequencer_if;
    logic [7:0] alu_in1;
    logic [7:0] alu_in2;
    logic       alu_cin;
    logic [2:0] alu_opcode;
    logic [7:0] alu_out;
    logic       alu_cout;
    logic       alu_z;

    modport master (
        output alu_in1, alu_in2, alu_cin, alu_opcode,
        input  alu_out, alu_cout, alu_z
    );

    modport slave (
        input  alu_in1, alu_in2, alu_cin, alu_opcode,
        output alu_out, alu_cout, alu_z
    );
endinterface

// File: rtl/alu_mp_sequencer.sv
// ---------------------------------------------------------------------------
// alu_mp_sequencer
// Issues one NBYTES-wide operation to an 8-bit ALU one byte per cycle, LSB
// byte first, chaining the ALU carry/borrow between bytes, and returns the
// wide result with the final carry and an all-bytes-zero flag.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   start                : request, accepted when not sequencing
//   op, cin_in           : ALU function, carry-in for byte 0 (ADDC/SUBC only)
//   opa, opb             : wide operands (opa = in1/minuend, opb = in2)
//   busy                 : high while bytes are being issued
//   done                 : one-cycle completion pulse
//   result, carry_out,
//   zero_out             : completion results, held until the next completion
//   alu                  : byte bus to the ALU (master modport)
// ---------------------------------------------------------------------------
`ifndef ADD_FN
`define ADD_FN  3'd0
`endif
`ifndef ADDC_FN
`define ADDC_FN 3'd1
`endif
`ifndef SUB_FN
`define SUB_FN  3'd2
`endif
`ifndef SUBC_FN
`define SUBC_FN 3'd3
`endif
`ifndef AND_FN
`define AND_FN  3'd4
`endif
`ifndef OR_FN
`define OR_FN   3'd5
`endif
`ifndef XOR_FN
`define XOR_FN  3'd6
`endif
`ifndef MASK_FN
`define MASK_FN 3'd7
`endif

module alu_mp_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic                  cin_in,
    input  logic [8*NBYTES-1:0]   opa,
    input  logic [8*NBYTES-1:0]   opb,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry_out,
    output logic                  zero_out,
    alu_mp_sequencer_if.master    alu
);

    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [IDXW-1:0]     idx;
    logic [8*NBYTES-1:0] opa_q;
    logic [8*NBYTES-1:0] opb_q;
    logic [8*NBYTES-1:0] work;
    logic [8*NBYTES-1:0] work_next;
    logic [2:0]          op_q;
    logic                carry_q;
    logic                zacc;

    // The accumulated result with the current ALU byte merged in; used both
    // for the running accumulator and for the final result so the last byte
    // lands in result on the completing edge.
    always_comb begin
        work_next = work;
        for (int b = 0; b < NBYTES; b++) begin
            if (idx == IDXW'(b)) begin
                work_next[8*b +: 8] = alu.alu_out;
            end
        end
    end

    // Upper bytes of a chained add/sub must consume the carry from the byte
    // below, so plain ADD/SUB are promoted to their carry forms after byte 0.
    always_comb begin
        alu.alu_in1    = 8'h00;
        alu.alu_in2    = 8'h00;
        alu.alu_cin    = 1'b0;
        alu.alu_opcode = `ADD_FN;
        if (state == RUN) begin
            alu.alu_in1 = 8'(opa_q >> {idx, 3'b000});
            alu.alu_in2 = 8'(opb_q >> {idx, 3'b000});
            alu.alu_cin = carry_q;
            if (idx == '0) begin
                alu.alu_opcode = op_q;
            end else begin
                case (op_q)
                    `ADD_FN, `ADDC_FN: alu.alu_opcode = `ADDC_FN;
                    `SUB_FN, `SUBC_FN: alu.alu_opcode = `SUBC_FN;
                    default:           alu.alu_opcode = op_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            op_q      <= '0;
            work      <= '0;
            carry_q   <= 1'b0;
            zacc      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero_out  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                // DONE behaves like IDLE so a request in the completion
                // cycle starts the next operation back-to-back.
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (start) begin
                        opa_q   <= opa;
                        opb_q   <= opb;
                        op_q    <= op;
                        idx     <= '0;
                        zacc    <= 1'b1;
                        carry_q <= ((op == `ADDC_FN) || (op == `SUBC_FN)) ? cin_in : 1'b0;
                        state   <= RUN;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    work    <= work_next;
                    carry_q <= alu.alu_cout;
                    zacc    <= zacc & alu.alu_z;
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        idx       <= '0;
                        result    <= work_next;
                        carry_out <= alu.alu_cout;
                        zero_out  <= zacc & alu.alu_z;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_mp_sequencer
// Self-checking bench for alu_mp_sequencer with NBYTES=4. A behavioural
// 8-bit ALU sits on the byte bus; expected wide results come from plain
// 33-bit arithmetic on the whole operands, plus literal directed vectors.
// ---------------------------------------------------------------------------
module tb_alu_mp_sequencer;

    localparam int N = 4;
    localparam int W = 8 * N;

    localparam logic [2:0] ADD_F  = 3'd0;
    localparam logic [2:0] ADDC_F = 3'd1;
    localparam logic [2:0] SUB_F  = 3'd2;
    localparam logic [2:0] SUBC_F = 3'd3;
    localparam logic [2:0] AND_F  = 3'd4;
    localparam logic [2:0] OR_F   = 3'd5;
    localparam logic [2:0] XOR_F  = 3'd6;
    localparam logic [2:0] MASK_F = 3'd7;

    typedef struct packed {
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] r;
        logic         co;
        logic         z;
    } vec_t;

    localparam int NDV = 12;
    localparam vec_t DVEC [NDV] = '{
        '{ADD_F,  32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0},
        '{ADD_F,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1},
        '{SUB_F,  32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0},
        '{SUB_F,  32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0},
        '{SUBC_F, 32'h00000005, 32'h00000002, 1'b1, 32'h00000002, 1'b0, 1'b0},
        '{MASK_F, 32'hFFFF0000, 32'hFF00FF00, 1'b0, 32'h00FFFFFF, 1'b0, 1'b0},
        '{XOR_F,  32'hA5C31E77, 32'hA5C31E77, 1'b0, 32'h00000000, 1'b0, 1'b1},
        '{ADDC_F, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1},
        '{ADD_F,  32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 1'b0, 1'b0},
        '{SUBC_F, 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0},
        '{AND_F,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 1'b0, 1'b0},
        '{OR_F,   32'h0F0F0000, 32'h000000F0, 1'b0, 32'h0F0F00F0, 1'b0, 1'b0}
    };

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic         cin_in;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero_out;

    int checks;
    int failures;
    logic [N-1:0][2:0] seen_ops;

    alu_mp_sequencer_if alu_bus ();

    alu_mp_sequencer #(.NBYTES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .cin_in    (cin_in),
        .opa       (opa),
        .opb       (opb),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero_out  (zero_out),
        .alu       (alu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit ALU on the byte bus.
    logic [8:0] alu_t;
    always_comb begin
        alu_t = '0;
        case (alu_bus.alu_opcode)
            ADD_F:  alu_t = {1'b0, alu_bus.alu_in1} + {1'b0, alu_bus.alu_in2};
            ADDC_F: alu_t = {1'b0, alu_bus.alu_in1} + {1'b0, alu_bus.alu_in2} + {8'h00, alu_bus.alu_cin};
            SUB_F:  alu_t = {1'b0, alu_bus.alu_in1} - {1'b0, alu_bus.alu_in2};
            SUBC_F: alu_t = {1'b0, alu_bus.alu_in1} - {1'b0, alu_bus.alu_in2} - {8'h00, alu_bus.alu_cin};
            AND_F:  alu_t = {1'b0, alu_bus.alu_in1 & alu_bus.alu_in2};
            OR_F:   alu_t = {1'b0, alu_bus.alu_in1 | alu_bus.alu_in2};
            XOR_F:  alu_t = {1'b0, alu_bus.alu_in1 ^ alu_bus.alu_in2};
            MASK_F: alu_t = {1'b0, ~(alu_bus.alu_in1 & alu_bus.alu_in2)};
            default: alu_t = '0;
        endcase
    end
    assign alu_bus.alu_out  = alu_t[7:0];
    assign alu_bus.alu_cout = alu_t[8];
    assign alu_bus.alu_z    = (alu_t[7:0] == 8'h00);

    // Whole-operand reference: the wide op is just one 33-bit computation.
    function automatic void model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, output logic [W-1:0] r, output logic co, output logic z);
        logic [W:0] t;
        logic       ci;
        ci = (f == ADDC_F || f == SUBC_F) ? c : 1'b0;
        case (f)
            ADD_F, ADDC_F: t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            SUB_F, SUBC_F: t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
            AND_F:         t = {1'b0, a & b};
            OR_F:          t = {1'b0, a | b};
            XOR_F:         t = {1'b0, a ^ b};
            default:       t = {1'b0, ~(a & b)};
        endcase
        r  = t[W-1:0];
        co = t[W];
        z  = (r == '0);
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return '1;
            1:       return '0;
            2:       return W'($urandom_range(0, 3));
            default: return W'($urandom);
        endcase
    endfunction

    // Issues one operation and returns the number of edges from the start
    // edge until done is seen (N expected; 20 means done never came).
    task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, output int cyc);
        @(negedge clk);
        op = f; opa = a; opb = b; cin_in = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        seen_ops = '0;
        while (done !== 1'b1 && cyc < 20) begin
            if (cyc < N) seen_ops[cyc] = alu_bus.alu_opcode;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, carry_out, zero_out} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b exp=0000", {busy, done, carry_out, zero_out});
        end
        checks++;
        if (result !== '0) begin
            failures++;
            $display("[TB] FAIL reset_result got=%h exp=0", result);
        end
        checks++;
        if ({alu_bus.alu_in1, alu_bus.alu_in2, alu_bus.alu_cin, alu_bus.alu_opcode} !== {8'h00, 8'h00, 1'b0, ADD_F}) begin
            failures++;
            $display("[TB] FAIL reset_alu_drive got=%h/%h/%b/%0d exp=0/0/0/%0d", alu_bus.alu_in1,
                     alu_bus.alu_in2, alu_bus.alu_cin, alu_bus.alu_opcode, ADD_F);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL idle_after_reset busy/done got=%b exp=00", {busy, done});
        end
    endtask

    task automatic test_directed();
        int cyc;
        for (int i = 0; i < NDV; i++) begin
            run_op(DVEC[i].f, DVEC[i].a, DVEC[i].b, DVEC[i].c, cyc);
            checks++;
            if (cyc !== N) begin
                failures++;
                $display("[TB] FAIL dir%0d_latency got=%0d exp=%0d", i, cyc, N);
            end
            checks++;
            if (result !== DVEC[i].r) begin
                failures++;
                $display("[TB] FAIL dir%0d_result got=%h exp=%h", i, result, DVEC[i].r);
            end
            checks++;
            if ({carry_out, zero_out} !== {DVEC[i].co, DVEC[i].z}) begin
                failures++;
                $display("[TB] FAIL dir%0d_carry_zero got=%b exp=%b", i, {carry_out, zero_out}, {DVEC[i].co, DVEC[i].z});
            end
            repeat (2) @(negedge clk);
            checks++;
            if ({busy, done, result} !== {2'b00, DVEC[i].r}) begin
                failures++;
                $display("[TB] FAIL dir%0d_hold got=%b/%h exp=00/%h", i, {busy, done}, result, DVEC[i].r);
            end
            checks++;
            if ({alu_bus.alu_in1, alu_bus.alu_opcode} !== {8'h00, ADD_F}) begin
                failures++;
                $display("[TB] FAIL dir%0d_idle_drive got=%h/%0d exp=00/%0d", i, alu_bus.alu_in1, alu_bus.alu_opcode, ADD_F);
            end
        end
    endtask

    task automatic test_opcode_seq();
        int cyc;
        run_op(ADD_F, 32'hFFFFFFFF, 32'h00000001, 1'b0, cyc);
        checks++;
        if (seen_ops !== {ADDC_F, ADDC_F, ADDC_F, ADD_F}) begin
            failures++;
            $display("[TB] FAIL opseq_add got=%h exp=%h", seen_ops, {ADDC_F, ADDC_F, ADDC_F, ADD_F});
        end
        run_op(SUB_F, 32'h12345678, 32'h00000001, 1'b1, cyc);
        checks++;
        if (seen_ops !== {SUBC_F, SUBC_F, SUBC_F, SUB_F}) begin
            failures++;
            $display("[TB] FAIL opseq_sub got=%h exp=%h", seen_ops, {SUBC_F, SUBC_F, SUBC_F, SUB_F});
        end
        run_op(XOR_F, 32'h12345678, 32'h87654321, 1'b1, cyc);
        checks++;
        if (seen_ops !== {XOR_F, XOR_F, XOR_F, XOR_F}) begin
            failures++;
            $display("[TB] FAIL opseq_xor got=%h exp=%h", seen_ops, {XOR_F, XOR_F, XOR_F, XOR_F});
        end
    endtask

    task automatic test_random();
        int           cyc;
        logic [2:0]   f;
        logic [W-1:0] a, b, er;
        logic         c, ec, ez;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = ($urandom_range(0, 5) == 0) ? a : pick_operand();
            c = 1'($urandom_range(0, 1));
            model(f, a, b, c, er, ec, ez);
            run_op(f, a, b, c, cyc);
            checks++;
            if (cyc !== N) begin
                failures++;
                $display("[TB] FAIL rnd%0d_latency got=%0d exp=%0d", i, cyc, N);
            end
            checks++;
            if ({result, carry_out, zero_out} !== {er, ec, ez}) begin
                failures++;
                $display("[TB] FAIL rnd%0d op=%0d a=%h b=%h c=%b got=%h/%b/%b exp=%h/%b/%b", i, f, a, b, c,
                         result, carry_out, zero_out, er, ec, ez);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_start_during_run();
        int           cyc;
        logic [W-1:0] er;
        logic         ec, ez;
        model(ADD_F, 32'h12345678, 32'h0FEDCBA9, 1'b0, er, ec, ez);
        @(negedge clk);
        op = ADD_F; opa = 32'h12345678; opb = 32'h0FEDCBA9; cin_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            if (cyc == 1) begin
                op = SUB_F; opa = 32'hDEADBEEF; opb = 32'h0BADF00D; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (cyc !== N) begin
            failures++;
            $display("[TB] FAIL ignore_start_latency got=%0d exp=%0d", cyc, N);
        end
        checks++;
        if ({result, carry_out, zero_out} !== {er, ec, ez}) begin
            failures++;
            $display("[TB] FAIL ignore_start_result got=%h/%b/%b exp=%h/%b/%b", result, carry_out, zero_out, er, ec, ez);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL ignore_start_no_second busy/done got=%b exp=00", {busy, done});
        end
    endtask

    task automatic test_back_to_back();
        int           cyc;
        logic [W-1:0] er;
        logic         ec, ez;
        run_op(ADD_F, 32'h0000FFFF, 32'h00000001, 1'b0, cyc);
        checks++;
        if (result !== 32'h00010000) begin
            failures++;
            $display("[TB] FAIL b2b_first got=%h exp=00010000", result);
        end
        model(SUBC_F, 32'h00001000, 32'h00000FFF, 1'b1, er, ec, ez);
        op = SUBC_F; opa = 32'h00001000; opb = 32'h00000FFF; cin_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== N + 1) begin
            failures++;
            $display("[TB] FAIL b2b_spacing got=%0d exp=%0d", cyc, N + 1);
        end
        checks++;
        if ({result, carry_out, zero_out} !== {er, ec, ez}) begin
            failures++;
            $display("[TB] FAIL b2b_second got=%h/%b/%b exp=%h/%b/%b", result, carry_out, zero_out, er, ec, ez);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int pulses;
        run_op(OR_F, 32'h00C0FFEE, 32'h11000000, 1'b0, cyc);
        @(negedge clk);
        op = ADD_F; opa = 32'h01010101; opb = 32'h02020202; cin_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, carry_out, zero_out} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL midrst_flags got=%b exp=0000", {busy, done, carry_out, zero_out});
        end
        checks++;
        if (result !== '0) begin
            failures++;
            $display("[TB] FAIL midrst_result got=%h exp=0", result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("[TB] FAIL midrst_no_done got=%0d exp=0", pulses);
        end
        run_op(SUB_F, 32'h00000000, 32'h00000000, 1'b0, cyc);
        checks++;
        if ({cyc, result, carry_out, zero_out} !== {N, 32'h0, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL midrst_recover got=%0d/%h/%b/%b exp=%0d/0/0/1", cyc, result, carry_out, zero_out, N);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        start    = 1'b0;
        op       = ADD_F;
        cin_in   = 1'b0;
        opa      = '0;
        opb      = '0;
        rst_n    = 1'b1;
        #2;
        test_reset();
        test_directed();
        test_opcode_seq();
        test_random();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
